// File: rtl/muldiv_wb_unit.sv
// muldiv_wb_unit: iterative shift-add multiply / restoring divide feeding register-file writeback; `define MULDIV_DIV_EN to build DIVU/REMU
module muldiv_wb_unit #(
  parameter int WIDTH = 32,
  parameter int AW = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [AW-1:0]    rd,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             wb_we,
  output logic [AW-1:0]    wb_addr,
  output logic [WIDTH-1:0] wb_data
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [1:0] op_q;
  logic [AW-1:0] rd_q;
  logic [WIDTH-1:0] b_q, result;
  logic [2*WIDTH-1:0] prod, prod_n;
  logic [WIDTH:0] psum;
  logic accept, last, skip;
  assign accept = state == IDLE && start;
  assign last = state == RUN && cnt == CW'(WIDTH - 1);
  always_comb begin
    psum = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, b_q} : '0);
    prod_n = {psum, prod[WIDTH-1:1]};
  end
`ifdef MULDIV_DIV_EN
  logic [WIDTH:0] rem, rem_n, sh, diff;
  logic [WIDTH-1:0] quo, quo_n;
  assign skip = 1'b0;
  // b==0 needs no special case: every subtract succeeds, giving all-ones quotient and remainder a
  always_comb begin
    sh = {rem[WIDTH-1:0], quo[WIDTH-1]};
    diff = sh - {1'b0, b_q};
    rem_n = diff[WIDTH] ? sh : diff;
    quo_n = {quo[WIDTH-2:0], ~diff[WIDTH]};
    result = op_q[1] ? (op_q[0] ? rem_n[WIDTH-1:0] : quo_n)
                     : (op_q[0] ? prod_n[2*WIDTH-1:WIDTH] : prod_n[WIDTH-1:0]);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      rem <= '0;
      quo <= '0;
    end else if (accept) begin
      rem <= '0;
      quo <= a;
    end else if (state == RUN) begin
      rem <= rem_n;
      quo <= quo_n;
    end
`else
  assign skip = op[1];
  assign result = op_q[1] ? '0 : (op_q[0] ? prod_n[2*WIDTH-1:WIDTH] : prod_n[WIDTH-1:0]);
`endif
  always_comb
    state_n = state == IDLE ? (start ? (skip ? DONE : RUN) : IDLE)
            : state == RUN  ? (last ? DONE : RUN)
            : IDLE;
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      cnt <= '0;
      op_q <= '0;
      rd_q <= '0;
      b_q <= '0;
      prod <= '0;
      busy <= 1'b0;
      wb_we <= 1'b0;
      wb_addr <= '0;
      wb_data <= '0;
    end else if (accept) begin
      cnt <= '0;
      op_q <= op;
      rd_q <= rd;
      b_q <= b;
      prod <= {{WIDTH{1'b0}}, a};
      busy <= 1'b1;
      if (skip) begin
        wb_we <= rd != '0;
        wb_addr <= rd;
        wb_data <= '0;
      end
    end else if (state == RUN) begin
      cnt <= cnt + 1'b1;
      prod <= prod_n;
      if (last) begin
        wb_we <= rd_q != '0;
        wb_addr <= rd_q;
        wb_data <= result;
      end
    end else if (state == DONE) begin
      wb_we <= 1'b0;
      busy <= 1'b0;
    end
endmodule

// File: tb/tb_muldiv_wb_unit.sv
// tb_muldiv_wb_unit: directed vectors, expected writes queued and checked by a writeback monitor
module tb_muldiv_wb_unit;
`ifdef MULDIV_DIV_EN
  localparam bit DIV = 1'b1;
`else
  localparam bit DIV = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [1:0] op = '0;
  logic [4:0] rd = '0;
  logic [31:0] a = '0, b = '0;
  logic busy, wb_we;
  logic [4:0] wb_addr;
  logic [31:0] wb_data;
  int vectors = 0, fails = 0, cyc = 0, nwrites = 0, we_cyc = 0;
  logic [36:0] q[$];

  muldiv_wb_unit #(.WIDTH(32), .AW(5)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .rd(rd), .a(a), .b(b),
    .busy(busy), .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk)
    if (wb_we === 1'b1) begin
      logic [36:0] e;
      nwrites++;
      we_cyc = cyc;
      if (q.size() == 0) chk("unexpected_write", {27'd0, wb_addr}, 32'hdead);
      else begin
        e = q.pop_front();
        chk("wb_addr", {27'd0, wb_addr}, {27'd0, e[36:32]});
        chk("wb_data", wb_data, e[31:0]);
      end
    end

  task automatic run_op(input logic [1:0] o, input logic [4:0] r, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] e, input bit poke);
    int c0, n, w0;
    bit skip;
    skip = o[1] && !DIV;
    @(negedge clk);
    op = o; rd = r; a = x; b = y; start = 1'b1;
    if (r != 0) q.push_back({r, e});
    w0 = nwrites;
    @(posedge clk);
    #1;
    c0 = cyc;
    start = 1'b0; a = ~x; b = ~y; rd = r + 5'd1; op = ~o;
    n = 0;
    while (n < 100) begin
      @(negedge clk);
      if (!busy) break;
      n++;
      if (poke && n == 5) begin
        start = 1'b1; op = 2'b00; a = 32'd9; b = 32'd9; rd = 5'd6;
      end
      if (poke && n == 6) start = 1'b0;
    end
    chk("busy_len", n, skip ? 32'd1 : 32'd33);
    chk("n_writes", nwrites - w0, (r != 0) ? 32'd1 : 32'd0);
    if (r != 0) chk("write_cycle", we_cyc - c0, skip ? 32'd0 : 32'd32);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int w0;
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_we", {31'd0, wb_we}, 32'd0);
    chk("rst_addr", {27'd0, wb_addr}, 32'd0);
    chk("rst_data", wb_data, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    run_op(2'b00, 5'd3, 32'd7, 32'd6, 32'd42, 0);
    run_op(2'b01, 5'd5, 32'hffffffff, 32'hffffffff, 32'hfffffffe, 0);
    run_op(2'b00, 5'd6, 32'hffffffff, 32'hffffffff, 32'h00000001, 0);
    run_op(2'b01, 5'd7, 32'h80000000, 32'd4, 32'd2, 0);
    run_op(2'b10, 5'd8, 32'd100, 32'd7, DIV ? 32'd14 : 32'd0, 0);
    run_op(2'b11, 5'd9, 32'd100, 32'd7, DIV ? 32'd2 : 32'd0, 0);
    run_op(2'b10, 5'd10, 32'd5, 32'd0, DIV ? 32'hffffffff : 32'd0, 0);
    run_op(2'b11, 5'd11, 32'd5, 32'd0, DIV ? 32'd5 : 32'd0, 0);
    run_op(2'b10, 5'd12, 32'hffffffff, 32'd1, DIV ? 32'hffffffff : 32'd0, 0);
    run_op(2'b00, 5'd4, 32'd3, 32'd5, 32'd15, 1);
    run_op(2'b00, 5'd0, 32'd2, 32'd2, 32'd4, 0);
    run_op(2'b10, 5'd0, 32'd9, 32'd3, 32'd3, 0);
    @(negedge clk);
    op = 2'b00; rd = 5'd3; a = 32'd7; b = 32'd6; start = 1'b1;
    w0 = nwrites;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(posedge clk);
    #5 reset = 1'b1;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_we", {31'd0, wb_we}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    chk("abort_no_write", nwrites - w0, 32'd0);
    chk("queue_drained", q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
